// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer: data/instruction widths, opcode
// codes driven on alu_c, the sequencer state encoding and the instruction
// field layout {op, rd, rs, rt}.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int INSTR_W = 12;
  localparam int REG_W   = 8;
  localparam int NREGS   = 8;
  localparam int ADDR_W  = $clog2(NREGS);
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB    = 3'b001;
  localparam logic [OP_W-1:0] OP_REM    = 3'b010;
  localparam logic [OP_W-1:0] OP_AND    = 3'b011;
  localparam logic [OP_W-1:0] OP_OR     = 3'b100;
  localparam logic [OP_W-1:0] OP_CONCAT = 3'b101;
  localparam logic [OP_W-1:0] OP_EQUAL  = 3'b110;
  localparam logic [OP_W-1:0] OP_LESS   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// 8 x 8-bit register file: three combinational read ports and one
// synchronous write port; asynchronous active-high reset clears every entry.
// A read of the entry being written returns the old value until the edge.
//
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_ra0/1/2, o_rd0/1/2    read address / read data (combinational)
//   i_we, i_wa, i_wd        write enable / address / data (rising edge)
// -----------------------------------------------------------------------------
module alu_regfile
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_ra0,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic [REG_W-1:0]  o_rd0,
  output logic [REG_W-1:0]  o_rd1,
  output logic [REG_W-1:0]  o_rd2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [REG_W-1:0]  i_wd
);

  logic [REG_W-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd0 = r_mem[i_ra0];
  assign o_rd1 = r_mem[i_ra1];
  assign o_rd2 = r_mem[i_ra2];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Four-state sequencer (IDLE -> FETCH -> EXEC -> WB) that reads two operands
// from an 8x8 register file, presents them to an external combinational ALU,
// and writes the 8-bit result back. External loads may write the register
// file while idle; a load attempted while busy is dropped and flagged.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   instr_valid/instr     instruction offer {op, rd, rs, rt}
//   instr_ready           accept strobe: IDLE and no load this cycle
//   load_en/addr/data     external register write request
//   rd_addr/rd_data       debug read port (combinational)
//   alu_a/alu_b/alu_c     ALU operands and select (zero outside EXEC/WB)
//   alu_result            combinational ALU result
//   busy                  any state other than IDLE
//   done                  one-cycle pulse in the writeback cycle
//   load_err              pulse when load_en arrives while busy
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [REG_W-1:0]   load_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [REG_W-1:0]   rd_data,
  output logic [REG_W-1:0]   alu_a,
  output logic [REG_W-1:0]   alu_b,
  output logic [OP_W-1:0]    alu_c,
  input  logic [REG_W-1:0]   alu_result,
  output logic               busy,
  output logic               done,
  output logic               load_err
);

  state_t            r_state;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [REG_W-1:0]  r_a;
  logic [REG_W-1:0]  r_b;
  logic [REG_W-1:0]  r_res;
  logic              r_busy;
  logic              r_done;

  instr_t            w_instr;
  logic              w_idle;
  logic              w_accept;
  logic              w_wb;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [REG_W-1:0]  w_wd;
  logic [REG_W-1:0]  w_rs_data;
  logic [REG_W-1:0]  w_rt_data;
  logic              w_drive_alu;

  assign w_instr = instr_t'(instr);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_wb    = (r_state == ST_WB);

  // instr_ready and load_err must react to load_en in the same cycle, so
  // they are decoded combinationally from the registered state.
  assign instr_ready = w_idle && !load_en;
  assign w_accept    = instr_valid && instr_ready;
  assign load_err    = load_en && !w_idle;

  // Single write port: writeback owns it in WB; otherwise only an idle load
  // may write (loads while busy are discarded).
  assign w_we = w_wb || (w_idle && load_en);
  assign w_wa = w_wb ? r_rd  : load_addr;
  assign w_wd = w_wb ? r_res : load_data;

  assign w_drive_alu = (r_state == ST_EXEC) || w_wb;
  assign alu_a = w_drive_alu ? r_a  : '0;
  assign alu_b = w_drive_alu ? r_b  : '0;
  assign alu_c = w_drive_alu ? r_op : '0;

  assign busy = r_busy;
  assign done = r_done;

  alu_regfile u_regfile (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ra0   (r_rs),
    .i_ra1   (r_rt),
    .i_ra2   (rd_addr),
    .o_rd0   (w_rs_data),
    .o_rd1   (w_rt_data),
    .o_rd2   (rd_data),
    .i_we    (w_we),
    .i_wa    (w_wa),
    .i_wd    (w_wd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= w_instr.op;
            r_rd    <= w_instr.rd;
            r_rs    <= w_instr.rs;
            r_rt    <= w_instr.rt;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        // Operands are captured here, a cycle before any writeback, so
        // rd==rs / rd==rt always see the pre-instruction value.
        ST_FETCH: begin
          r_a     <= w_rs_data;
          r_b     <= w_rt_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res   <= alu_result;
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer: a table of instructions with
// hand-computed results, a scoreboard queue of expected writebacks, and
// hand-written sequences for load collisions, read-during-write,
// back-to-back issue and reset mid-instruction.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_pkg::*;

  logic               clk;
  logic               reset;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               load_en;
  logic [2:0]         load_addr;
  logic [7:0]         load_data;
  logic [2:0]         rd_addr;
  logic [7:0]         rd_data;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [2:0]         alu_c;
  logic [7:0]         alu_result;
  logic               busy;
  logic               done;
  logic               load_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[12];

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_result  (alu_result),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err)
  );

  // Bench ALU: concat packs the low nibbles, remainder by zero yields 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_c)
      OP_ADD:    alu_result = alu_a + alu_b;
      OP_SUB:    alu_result = alu_a - alu_b;
      OP_REM:    alu_result = (alu_b == 8'h00) ? 8'h00 : (alu_a % alu_b);
      OP_AND:    alu_result = alu_a & alu_b;
      OP_OR:     alu_result = alu_a | alu_b;
      OP_CONCAT: alu_result = {alu_a[3:0], alu_b[3:0]};
      OP_EQUAL:  alu_result = {7'b0, alu_a == alu_b};
      OP_LESS:   alu_result = {7'b0, alu_a < alu_b};
      default:   alu_result = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    #1;
    chk("load_ready_low", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(name, {24'b0, rd_data}, 32'd0);
    end
  endtask

  task automatic run_instr(input vec_t v);
    int  n;
    sb_t e;
    do_load(v.rs, v.va);
    do_load(v.rt, v.vb);
    @(negedge clk);
    instr = {v.op, v.rd, v.rs, v.rt}; instr_valid = 1'b1;
    #1;
    chk("hs_ready", {31'b0, instr_ready}, 32'd1);
    sb_q.push_back('{rd: v.rd, val: v.exp});
    @(negedge clk);
    instr_valid = 1'b0; rd_addr = v.rd;
    #1;
    chk("fetch_busy",  {31'b0, busy}, 32'd1);
    chk("fetch_alu_a", {24'b0, alu_a}, 32'd0);
    chk("fetch_alu_c", {29'b0, alu_c}, 32'd0);
    @(negedge clk);
    #1;
    chk("exec_alu_a", {24'b0, alu_a}, {24'b0, v.va});
    chk("exec_alu_b", {24'b0, alu_b}, {24'b0, v.vb});
    chk("exec_alu_c", {29'b0, alu_c}, {29'b0, v.op});
    chk("exec_done",  {31'b0, done}, 32'd0);
    n = 0;
    while (!done && n < 6) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_latency", n, 32'd1);
    chk("wb_hold_alu_b", {24'b0, alu_b}, {24'b0, v.vb});
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else begin
      e = '{rd: 3'd0, val: 8'h00};
      chk("sb_underflow", 32'd1, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("done_once", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    rd_addr = e.rd;
    #1;
    chk("wb_result", {24'b0, rd_data}, {24'b0, e.val});
  endtask

  initial begin
    int  n;
    int  hs;
    int  dn;
    int  last_hs;
    int  pend;
    int  dcount;
    logic [7:0] m6;
    sb_t e;

    reset = 1'b1; instr_valid = 1'b0; instr = '0; load_en = 1'b0;
    load_addr = '0; load_data = '0; rd_addr = '0;

    vecs[0]  = '{OP_ADD,    3'd3, 3'd1, 3'd2, 8'h05, 8'h03, 8'h08};
    vecs[1]  = '{OP_EQUAL,  3'd4, 3'd1, 3'd2, 8'h07, 8'h07, 8'h01};
    vecs[2]  = '{OP_LESS,   3'd5, 3'd1, 3'd2, 8'h07, 8'h07, 8'h00};
    vecs[3]  = '{OP_SUB,    3'd6, 3'd1, 3'd2, 8'h05, 8'h08, 8'hFD};
    vecs[4]  = '{OP_REM,    3'd7, 3'd1, 3'd2, 8'h17, 8'h05, 8'h03};
    vecs[5]  = '{OP_AND,    3'd3, 3'd1, 3'd2, 8'hF0, 8'h3C, 8'h30};
    vecs[6]  = '{OP_OR,     3'd4, 3'd1, 3'd2, 8'hF0, 8'h0F, 8'hFF};
    vecs[7]  = '{OP_CONCAT, 3'd5, 3'd1, 3'd2, 8'hA5, 8'h3C, 8'h5C};
    vecs[8]  = '{OP_LESS,   3'd6, 3'd1, 3'd2, 8'h03, 8'h07, 8'h01};
    vecs[9]  = '{OP_ADD,    3'd7, 3'd2, 3'd1, 8'hFF, 8'h02, 8'h01};
    vecs[10] = '{OP_SUB,    3'd1, 3'd1, 3'd1, 8'h10, 8'h10, 8'h00};
    vecs[11] = '{OP_ADD,    3'd2, 3'd2, 3'd2, 8'h40, 8'h40, 8'h80};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    chk("rst_done",     {31'b0, done}, 32'd0);
    chk("rst_ready",    {31'b0, instr_ready}, 32'd1);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    check_all_zero("rst_reg");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven instructions
    for (int i = 0; i < 12; i++) run_instr(vecs[i]);

    // Load while busy is dropped; debug read sees old value during WB
    do_load(3'd1, 8'h33);
    do_load(3'd3, 8'h11);
    @(negedge clk);
    instr = {OP_ADD, 3'd3, 3'd1, 3'd1}; instr_valid = 1'b1;
    #1;
    chk("ld_busy_hs", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    load_en = 1'b1; load_addr = 3'd1; load_data = 8'hAA;
    #1;
    chk("exec_load_err",  {31'b0, load_err}, 32'd1);
    chk("exec_ready_low", {31'b0, instr_ready}, 32'd0);
    chk("exec_alu_a_33",  {24'b0, alu_a}, 32'h33);
    @(negedge clk);
    load_en = 1'b0; rd_addr = 3'd3;
    #1;
    chk("wb_done",       {31'b0, done}, 32'd1);
    chk("load_err_once", {31'b0, load_err}, 32'd0);
    chk("rdw_old",       {24'b0, rd_data}, 32'h11);
    @(negedge clk);
    #1;
    chk("rdw_new", {24'b0, rd_data}, 32'h66);
    rd_addr = 3'd1;
    #1;
    chk("load_dropped", {24'b0, rd_data}, 32'h33);

    // Load and instruction in the same idle cycle: load first
    @(negedge clk);
    load_en = 1'b1; load_addr = 3'd1; load_data = 8'hAA;
    instr_valid = 1'b1; instr = {OP_ADD, 3'd2, 3'd1, 3'd0};
    #1;
    chk("ldpri_ready", {31'b0, instr_ready}, 32'd0);
    chk("ldpri_busy",  {31'b0, busy}, 32'd0);
    @(negedge clk);
    load_en = 1'b0;
    #1;
    chk("ldpri_ready_next", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("ldpri_accepted", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 6) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ldpri_latency", n, 32'd2);
    @(negedge clk);
    rd_addr = 3'd2;
    #1;
    chk("ldpri_result", {24'b0, rd_data}, 32'hAA);
    rd_addr = 3'd1;
    #1;
    chk("ldpri_r1", {24'b0, rd_data}, 32'hAA);

    // Back-to-back issue with instr_valid held high
    do_load(3'd6, 8'h01);
    do_load(3'd7, 8'h01);
    m6 = 8'h01; hs = 0; dn = 0; last_hs = -1; pend = 0;
    e = '{rd: 3'd0, val: 8'h00};
    rd_addr = 3'd6;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      instr_valid = (k < 17);
      instr = {OP_ADD, 3'd6, 3'd6, 3'd7};
      #1;
      if (pend != 0) begin
        chk("b2b_wb_val", {24'b0, rd_data}, {24'b0, e.val});
        pend = 0;
      end
      if (done) begin
        dn++;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          pend = 1;
        end else chk("b2b_spurious_done", 32'd1, 32'd0);
      end
      if (instr_valid && instr_ready) begin
        if (last_hs >= 0) chk("b2b_spacing", k - last_hs, 32'd4);
        last_hs = k;
        hs++;
        m6 = m6 + 8'h01;
        sb_q.push_back('{rd: 3'd6, val: m6});
      end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", hs, 32'd5);
    chk("b2b_dones",   dn, 32'd5);
    chk("b2b_sb_left", sb_q.size(), 32'd0);

    // Reset asserted during EXEC aborts the instruction
    do_load(3'd2, 8'h55);
    @(negedge clk);
    instr = {OP_ADD, 3'd3, 3'd2, 3'd2}; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_exec_a", {24'b0, alu_a}, 32'h55);
    reset = 1'b1;
    #1;
    chk("midrst_busy",  {31'b0, busy}, 32'd0);
    chk("midrst_ready", {31'b0, instr_ready}, 32'd1);
    chk("midrst_done",  {31'b0, done}, 32'd0);
    chk("midrst_alu_a", {24'b0, alu_a}, 32'd0);
    chk("midrst_alu_c", {29'b0, alu_c}, 32'd0);
    check_all_zero("midrst_reg");
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 32'd0);
    chk("midrst_idle",    {31'b0, busy}, 32'd0);
    rd_addr = 3'd3;
    #1;
    chk("midrst_no_wb", {24'b0, rd_data}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
